// File: rtl/valid_data_arbiter_if.sv
// rtl/valid_data_arbiter_if.sv - requester and downstream handshake bundle for valid_data_arbiter
interface valid_data_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int BIT_OF_DATA = 8,
  parameter int SRC_W       = 2
) ();
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*BIT_OF_DATA-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ack;
  logic                           out_valid;
  logic                           out_ready;
  logic [BIT_OF_DATA-1:0]         out_data;
  logic [SRC_W-1:0]               out_src;

  modport master (
    output req, req_data, out_ready,
    input  req_ack, out_valid, out_data, out_src
  );

  modport slave (
    input  req, req_data, out_ready,
    output req_ack, out_valid, out_data, out_src
  );
endinterface

// File: rtl/valid_data_arbiter.sv
// rtl/valid_data_arbiter.sv - round-robin arbiter feeding one shared holding register
module valid_data_arbiter #(
  parameter int                     NUM_REQ     = 4,
  parameter int                     BIT_OF_DATA = 8,
  parameter int                     SRC_W       = 2,
  parameter logic [BIT_OF_DATA-1:0] DEF_VALUE   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  valid_data_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       ptr_nxt;
  logic [PTR_W-1:0]       grant_idx;
  logic [PTR_W:0]         idx;
  logic                   found;
  logic                   load_en;
  logic [NUM_REQ-1:0]     ack;
  logic [BIT_OF_DATA-1:0] grant_data;
  logic [BIT_OF_DATA-1:0] data_q;
  logic [SRC_W-1:0]       src_q;

  // Gated by rst_n so no grant is ever shown while the register is held in reset.
  assign load_en = rst_n && (|bus.req) && ((state == EMPTY) || bus.out_ready);

  // Search ptr, ptr+1, ... with an explicit wrap so NUM_REQ need not be a power of two.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(NUM_REQ)) begin
        idx = idx - (PTR_W+1)'(NUM_REQ);
      end
      if (!found && bus.req[idx[PTR_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    ack        = '0;
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        grant_data = bus.req_data[i*BIT_OF_DATA +: BIT_OF_DATA];
        ack[i]     = load_en;
      end
    end
  end

  always_comb begin
    ptr_nxt = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
  end

  always_comb begin
    state_nxt = state;
    if (load_en) begin
      state_nxt = FULL;
    end else if ((state == FULL) && bus.out_ready) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // The pointer moves only on a grant; stalls leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      data_q <= DEF_VALUE;
      src_q  <= '0;
    end else if (load_en) begin
      ptr    <= ptr_nxt;
      data_q <= grant_data;
      src_q  <= SRC_W'(grant_idx);
    end
  end

  assign bus.req_ack   = ack;
  assign bus.out_valid = (state == FULL);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;

endmodule

// File: tb/tb_valid_data_arbiter.sv
// tb/tb_valid_data_arbiter.sv - directed self-checking bench for valid_data_arbiter
module tb_valid_data_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  valid_data_arbiter_if #(.NUM_REQ(4), .BIT_OF_DATA(8), .SRC_W(2)) bus ();

  valid_data_arbiter #(
    .NUM_REQ(4), .BIT_OF_DATA(8), .SRC_W(2), .DEF_VALUE(8'h00)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b1;
    bus.req       = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    #1;
    rst_n   = 1'b0;
    bus.req = 4'b1111;
    #2;
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_data",  32'(bus.out_data),  32'h00);
    check("rst_src",   32'(bus.out_src),   32'h0);
    check("rst_ack",   32'(bus.req_ack),   32'h0);
    step();
    check("rst_hold_ack", 32'(bus.req_ack), 32'h0);
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      check("idle_valid", 32'(bus.out_valid), 32'h0);
      check("idle_ack",   32'(bus.req_ack),   32'h0);
      check("idle_data",  32'(bus.out_data),  32'h00);
    end

    // single request from requester 2
    bus.req      = 4'b0100;
    bus.req_data = 32'h00A5_0000;
    #1;
    check("single_ack", 32'(bus.req_ack), 32'h4);
    step();
    bus.req = '0;
    check("single_valid", 32'(bus.out_valid), 32'h1);
    check("single_data",  32'(bus.out_data),  32'hA5);
    check("single_src",   32'(bus.out_src),   32'h2);

    // stall: ptr=3, requesters 0 and 1 wait
    bus.out_ready = 1'b0;
    bus.req       = 4'b0011;
    bus.req_data  = 32'h4433_2211;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall_ack", 32'(bus.req_ack), 32'h0);
      step();
      check("stall_data",  32'(bus.out_data),  32'hA5);
      check("stall_valid", 32'(bus.out_valid), 32'h1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("wrap_ack", 32'(bus.req_ack), 32'h1);
    step();
    check("wrap_data", 32'(bus.out_data), 32'h11);
    check("wrap_src",  32'(bus.out_src),  32'h0);

    // simultaneous consume and load from requester 3
    bus.req = 4'b1000;
    #1;
    check("simul_ack", 32'(bus.req_ack), 32'h8);
    step();
    check("simul_valid", 32'(bus.out_valid), 32'h1);
    check("simul_data",  32'(bus.out_data),  32'h44);
    check("simul_src",   32'(bus.out_src),   32'h3);
    bus.req = '0;
    step();
    check("drain_valid", 32'(bus.out_valid), 32'h0);
    check("drain_data",  32'(bus.out_data),  32'h44);
    check("drain_src",   32'(bus.out_src),   32'h3);

    // fairness: all four requesting, ptr=0
    bus.req      = 4'b1111;
    bus.req_data = 32'h1312_1110;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("rr_ack", 32'(bus.req_ack), 32'(1 << (c % 4)));
      step();
      check("rr_valid", 32'(bus.out_valid), 32'h1);
      check("rr_src",   32'(bus.out_src),   32'(c % 4));
      check("rr_data",  32'(bus.out_data),  32'(8'h10 + (c % 4)));
    end
    bus.req = '0;
    step();
    check("rr_drain", 32'(bus.out_valid), 32'h0);

    // async reset mid-operation; ptr=2 so requester 0 is reached by wrap
    bus.req      = 4'b0001;
    bus.req_data = 32'h0000_003C;
    #1;
    check("pre_rst_ack", 32'(bus.req_ack), 32'h1);
    step();
    check("pre_rst_data", 32'(bus.out_data), 32'h3C);
    bus.req       = '0;
    bus.out_ready = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(bus.out_valid), 32'h0);
    check("async_data",  32'(bus.out_data),  32'h00);
    check("async_src",   32'(bus.out_src),   32'h0);
    bus.out_ready = 1'b1;
    bus.req       = 4'b1001;
    bus.req_data  = 32'h5500_0066;
    #1;
    check("inrst_ack", 32'(bus.req_ack), 32'h0);
    step();
    rst_n = 1'b1;
    #1;
    check("post_rst_ack", 32'(bus.req_ack), 32'h1);
    step();
    check("post_rst_data", 32'(bus.out_data), 32'h66);
    check("post_rst_src",  32'(bus.out_src),  32'h0);
    bus.req = 4'b1000;
    #1;
    check("post_rst_ack3", 32'(bus.req_ack), 32'h8);
    step();
    check("post_rst_data3", 32'(bus.out_data), 32'h55);
    check("post_rst_src3",  32'(bus.out_src),  32'h3);
    bus.req = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
